id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined MIPS datapath. It sits directly downstream of the main control unit and the register file. It latches the decoded control bundle, operands, immediate and register specifiers for the EX stage. It also detects load-use hazards, asserting a stall toward the PC and IF/ID while injecting a bubble. It honours a flush from branch resolution and a global hold, and keeps a saturating bubble counter for diagnostics.

---
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoded ID-stage fields in, registered EX-stage copies out,
// plus the branch-flush / memory-hold controls and the load-use stall back upstream.
interface id_ex_if #(
    parameter int DW = 32
);
    logic          id_branch_eq;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_memtoreg;
    logic          id_regdst;
    logic          id_regwrite;
    logic          id_alusrc;
    logic [1:0]    id_aluop;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc_plus4;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;

    logic          flush;
    logic          hold;

    logic          ex_branch_eq;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;
    logic          ex_regdst;
    logic          ex_regwrite;
    logic          ex_alusrc;
    logic [1:0]    ex_aluop;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pc_plus4;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_rd;

    logic          stall;

    // Upstream side: control unit, register file and branch/memory logic.
    modport master (
        output id_branch_eq, id_memread, id_memwrite, id_memtoreg,
               id_regdst, id_regwrite, id_alusrc, id_aluop,
               id_rd1, id_rd2, id_imm, id_pc_plus4, id_rs, id_rt, id_rd,
               flush, hold,
        input  ex_branch_eq, ex_memread, ex_memwrite, ex_memtoreg,
               ex_regdst, ex_regwrite, ex_alusrc, ex_aluop,
               ex_rd1, ex_rd2, ex_imm, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
               stall
    );

    // The ID/EX register itself.
    modport slave (
        input  id_branch_eq, id_memread, id_memwrite, id_memtoreg,
               id_regdst, id_regwrite, id_alusrc, id_aluop,
               id_rd1, id_rd2, id_imm, id_pc_plus4, id_rs, id_rt, id_rd,
               flush, hold,
        output ex_branch_eq, ex_memread, ex_memwrite, ex_memtoreg,
               ex_regdst, ex_regwrite, ex_alusrc, ex_aluop,
               ex_rd1, ex_rd2, ex_imm, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
               stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection,
// branch flush, global hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_if.slave        bus,
    output logic [CW-1:0] bubble_cnt
);

    typedef struct packed {
        logic       branch_eq;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc_plus4;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
    } data_t;

    ctrl_t         id_ctrl;
    data_t         id_data;
    ctrl_t         ctrl_d, ctrl_q;
    data_t         data_d, data_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          rt_used;
    logic          hazard;

    assign id_ctrl = {bus.id_branch_eq, bus.id_memread, bus.id_memwrite, bus.id_memtoreg,
                      bus.id_regdst, bus.id_regwrite, bus.id_alusrc, bus.id_aluop};
    assign id_data = {bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_pc_plus4,
                      bus.id_rs, bus.id_rt, bus.id_rd};

    // rt is a source for R-type, sw and beq; for lw it is the destination.
    assign rt_used = bus.id_regdst | bus.id_memwrite | bus.id_branch_eq;
    assign hazard  = ctrl_q.memread && (data_q.rt != 5'd0) &&
                     ((data_q.rt == bus.id_rs) || (rt_used && (data_q.rt == bus.id_rt)));

    // Hold does not mask the stall: upstream must stay frozen until the bubble goes in.
    assign bus.stall = hazard & ~reset & ~bus.flush;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (bus.flush) begin
            ctrl_d = '0;
            data_d = '0;
            cnt_d  = cnt_inc;
        end else if (bus.hold) begin
            ctrl_d = ctrl_q;
        end else if (hazard) begin
            ctrl_d = '0;
            data_d = id_data;
            cnt_d  = cnt_inc;
        end else begin
            ctrl_d = id_ctrl;
            data_d = id_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.ex_branch_eq = ctrl_q.branch_eq;
    assign bus.ex_memread   = ctrl_q.memread;
    assign bus.ex_memwrite  = ctrl_q.memwrite;
    assign bus.ex_memtoreg  = ctrl_q.memtoreg;
    assign bus.ex_regdst    = ctrl_q.regdst;
    assign bus.ex_regwrite  = ctrl_q.regwrite;
    assign bus.ex_alusrc    = ctrl_q.alusrc;
    assign bus.ex_aluop     = ctrl_q.aluop;
    assign bus.ex_rd1       = data_q.rd1;
    assign bus.ex_rd2       = data_q.rd2;
    assign bus.ex_imm       = data_q.imm;
    assign bus.ex_pc_plus4  = data_q.pc_plus4;
    assign bus.ex_rs        = data_q.rs;
    assign bus.ex_rt        = data_q.rt;
    assign bus.ex_rd        = data_q.rd;
    assign bubble_cnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven pipeline sequence with a
// scoreboard queue, plus a hand-written counter saturation sequence at CW=2.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int CW = 16;

    // {branch_eq, memread, memwrite, memtoreg, regdst, regwrite, alusrc, aluop[1:0]}
    localparam logic [8:0] C_R   = 9'b000011010;
    localparam logic [8:0] C_LW  = 9'b010101100;
    localparam logic [8:0] C_SW  = 9'b001000100;
    localparam logic [8:0] C_BEQ = 9'b100000001;

    typedef enum logic [1:0] {E_ZERO, E_LOAD, E_HOLD, E_BUBBLE} kind_e;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct {
        logic          rst;
        logic          fl;
        logic          hd;
        bundle_t       in;
        logic          exp_stall;
        kind_e         kind;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    typedef struct {
        bundle_t       ex;
        logic          ctrl_only;
        logic [CW-1:0] cnt;
        int            row;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reset2 = 1'b1;
    logic [CW-1:0] bubble_cnt;
    logic [1:0]    bubble_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    id_ex_if #(.DW(DW)) bus ();
    id_ex_if #(.DW(DW)) bus2 ();

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .bubble_cnt (bubble_cnt)
    );

    id_ex_stage #(.DW(DW), .CW(2)) dut_sat (
        .clk        (clk),
        .reset      (reset2),
        .bus        (bus2.slave),
        .bubble_cnt (bubble_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bundle_t ins(logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                                    logic [4:0] rd, logic [31:0] rd1);
        bundle_t b;
        b.ctrl = c;
        b.rd1  = rd1;
        b.rd2  = rd1 ^ 32'h5A5A_0000;
        b.imm  = rd1 + 32'h0000_1000;
        b.pc   = 32'h0040_0000 + rd1;
        b.rs   = rs;
        b.rt   = rt;
        b.rd   = rd;
        return b;
    endfunction

    function automatic vec_t row(logic rst, logic fl, logic hd, bundle_t b,
                                 logic st, kind_e k, int cnt);
        vec_t v;
        v.rst       = rst;
        v.fl        = fl;
        v.hd        = hd;
        v.in        = b;
        v.exp_stall = st;
        v.kind      = k;
        v.exp_cnt   = CW'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input int r, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, r, act, exp);
        end
    endtask

    task automatic drive1(input bundle_t b, input logic fl, input logic hd);
        {bus.id_branch_eq, bus.id_memread, bus.id_memwrite, bus.id_memtoreg,
         bus.id_regdst, bus.id_regwrite, bus.id_alusrc, bus.id_aluop} = b.ctrl;
        bus.id_rd1      = b.rd1;
        bus.id_rd2      = b.rd2;
        bus.id_imm      = b.imm;
        bus.id_pc_plus4 = b.pc;
        bus.id_rs       = b.rs;
        bus.id_rt       = b.rt;
        bus.id_rd       = b.rd;
        bus.flush       = fl;
        bus.hold        = hd;
    endtask

    task automatic drive2(input bundle_t b, input logic fl, input logic hd);
        {bus2.id_branch_eq, bus2.id_memread, bus2.id_memwrite, bus2.id_memtoreg,
         bus2.id_regdst, bus2.id_regwrite, bus2.id_alusrc, bus2.id_aluop} = b.ctrl;
        bus2.id_rd1      = b.rd1;
        bus2.id_rd2      = b.rd2;
        bus2.id_imm      = b.imm;
        bus2.id_pc_plus4 = b.pc;
        bus2.id_rs       = b.rs;
        bus2.id_rt       = b.rt;
        bus2.id_rd       = b.rd;
        bus2.flush       = fl;
        bus2.hold        = hd;
    endtask

    task automatic sample1(output bundle_t b);
        b.ctrl = {bus.ex_branch_eq, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg,
                  bus.ex_regdst, bus.ex_regwrite, bus.ex_alusrc, bus.ex_aluop};
        b.rd1  = bus.ex_rd1;
        b.rd2  = bus.ex_rd2;
        b.imm  = bus.ex_imm;
        b.pc   = bus.ex_pc_plus4;
        b.rs   = bus.ex_rs;
        b.rt   = bus.ex_rt;
        b.rd   = bus.ex_rd;
    endtask

    initial begin
        bundle_t prev;
        bundle_t act;
        exp_t    e;

        drive1(ins(C_LW, 5'd5, 5'd5, 5'd0, 32'hDEAD_BEEF), 1'b0, 1'b0);
        drive2(ins(9'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0, 1'b0);

        //              rst  fl   hd   instruction                                stall kind     cnt
        vecs.push_back(row(1'b1, 1'b0, 1'b0, ins(C_R,   5'd1,  5'd2,  5'd3,  32'h10),  1'b0, E_ZERO,   0));
        vecs.push_back(row(1'b1, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd5,  5'd0,  32'h77),  1'b0, E_ZERO,   0));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd1,  5'd2,  5'd3,  32'h10),  1'b0, E_LOAD,   0));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd5,  5'd0,  32'h100), 1'b0, E_LOAD,   0));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd5,  5'd6,  5'd7,  32'h200), 1'b1, E_BUBBLE, 1));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd5,  5'd6,  5'd7,  32'h200), 1'b0, E_LOAD,   1));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd2,  5'd5,  5'd0,  32'h300), 1'b0, E_LOAD,   1));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd3,  5'd5,  5'd0,  32'h400), 1'b0, E_LOAD,   1));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_SW,  5'd3,  5'd5,  5'd0,  32'h500), 1'b1, E_BUBBLE, 2));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd0,  5'd0,  32'h600), 1'b0, E_LOAD,   2));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd0,  5'd0,  5'd4,  32'h700), 1'b0, E_LOAD,   2));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd8,  5'd0,  32'h800), 1'b0, E_LOAD,   2));
        vecs.push_back(row(1'b0, 1'b1, 1'b0, ins(C_BEQ, 5'd9,  5'd8,  5'd0,  32'h900), 1'b0, E_ZERO,   3));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd10, 5'd0,  32'hA00), 1'b0, E_LOAD,   3));
        vecs.push_back(row(1'b0, 1'b0, 1'b1, ins(C_R,   5'd10, 5'd2,  5'd11, 32'hB00), 1'b1, E_HOLD,   3));
        vecs.push_back(row(1'b0, 1'b0, 1'b1, ins(C_R,   5'd10, 5'd12, 5'd13, 32'hB10), 1'b1, E_HOLD,   3));
        vecs.push_back(row(1'b0, 1'b0, 1'b1, ins(C_R,   5'd3,  5'd10, 5'd14, 32'hB20), 1'b1, E_HOLD,   3));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd10, 5'd2,  5'd11, 32'hB00), 1'b1, E_BUBBLE, 4));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd10, 5'd2,  5'd11, 32'hB00), 1'b0, E_LOAD,   4));
        vecs.push_back(row(1'b0, 1'b1, 1'b1, ins(C_R,   5'd1,  5'd2,  5'd3,  32'hC00), 1'b0, E_ZERO,   5));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_LW,  5'd1,  5'd6,  5'd0,  32'hD00), 1'b0, E_LOAD,   5));
        vecs.push_back(row(1'b1, 1'b0, 1'b0, ins(C_R,   5'd6,  5'd2,  5'd9,  32'hE00), 1'b0, E_ZERO,   0));
        vecs.push_back(row(1'b0, 1'b0, 1'b0, ins(C_R,   5'd1,  5'd2,  5'd3,  32'h10),  1'b0, E_LOAD,   0));

        prev = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            drive1(vecs[i].in, vecs[i].fl, vecs[i].hd);
            #1;
            check("stall", i, 256'(bus.stall), 256'(vecs[i].exp_stall));

            e.row       = i;
            e.cnt       = vecs[i].exp_cnt;
            e.ctrl_only = 1'b0;
            case (vecs[i].kind)
                E_ZERO:   e.ex = '0;
                E_LOAD:   e.ex = vecs[i].in;
                E_HOLD:   e.ex = prev;
                default: begin
                    e.ex        = vecs[i].in;
                    e.ex.ctrl   = '0;
                    e.ctrl_only = 1'b1;
                end
            endcase
            prev = e.ex;
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty row=%0d actual=0 required=1", i);
            end else begin
                e = sb.pop_front();
                sample1(act);
                if (e.ctrl_only)
                    check("ex_ctrl", e.row, 256'(act.ctrl), 256'(e.ex.ctrl));
                else
                    check("ex_bundle", e.row, 256'(act), 256'(e.ex));
                check("bubble_cnt", e.row, 256'(bubble_cnt), 256'(e.cnt));
            end
        end

        // Saturation at CW=2: five back-to-back flushes must stick at 3.
        @(negedge clk);
        reset2 = 1'b1;
        drive2(ins(C_R, 5'd1, 5'd2, 5'd3, 32'h55), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("sat_reset_cnt", 0, 256'(bubble_cnt2), 256'(2'd0));
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            reset2 = 1'b0;
            drive2(ins(C_R, 5'd1, 5'd2, 5'd3, 32'h55 + 32'(k)), 1'b1, 1'b0);
            #1;
            check("sat_stall", k, 256'(bus2.stall), 256'(1'b0));
            @(posedge clk);
            #1;
            check("sat_cnt", k, 256'(bubble_cnt2), 256'((k < 3) ? k : 3));
            check("sat_ex_zero", k, 256'({bus2.ex_regwrite, bus2.ex_regdst, bus2.ex_aluop, bus2.ex_rd1}),
                  256'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
